// File: rtl/game_board_store.sv
// Board register for the matrix battleship game: layout preview/selection,
// column-by-column load into a working board, shot tracking and game-over.
module game_board_store #(
  parameter int COLS  = 5,
  parameter int ROWS  = 7,
  parameter int GAMES = 4,
  parameter logic [GAMES*COLS*ROWS-1:0] LAYOUTS = {
    70'd0,
    7'b1000111, 7'b1110111, 7'b1011101, 7'b1011100, 7'b0001101,
    7'b1110111, 7'b1000111, 7'b0110101, 7'b0011101, 7'b0111100
  },
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int SW = $clog2(COLS*ROWS+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 register_game,
  input  logic [GAMES-1:0]     game_selected,
  input  logic                 shot_valid,
  input  logic [CW-1:0]        shot_col,
  input  logic [RW-1:0]        shot_row,
  output logic [COLS*ROWS-1:0] board_out,
  output logic [COLS*ROWS-1:0] hits_out,
  output logic [SW-1:0]        ships_left,
  output logic                 busy,
  output logic                 playing,
  output logic                 game_over,
  output logic                 shot_done,
  output logic                 shot_hit,
  output logic                 shot_dup
);

  localparam int GW = (GAMES > 1) ? $clog2(GAMES) : 1;
  localparam int IW = $clog2(COLS*ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);

  typedef enum logic [1:0] {SELECT, LOAD, PLAY, OVER} state_t;

  state_t               state;
  logic [COLS*ROWS-1:0] board_reg;
  logic [COLS*ROWS-1:0] hits_reg;
  logic [SW-1:0]        ships_reg;
  logic [CW-1:0]        load_col_idx;
  logic [GW-1:0]        game_idx;
  logic                 busy_reg, playing_reg, over_reg;
  logic                 done_reg, hit_reg, dup_reg;

  logic                 sel_valid;
  logic [GW-1:0]        sel_idx;
  logic [COLS*ROWS-1:0] sel_board;
  logic [ROWS-1:0]      load_col;
  logic [SW-1:0]        load_pop;
  logic [SW-1:0]        load_sum;
  logic                 shot_ok;
  logic [IW-1:0]        shot_idx;

  // Decode the selector, pick the preview layout and the column being loaded.
  always_comb begin
    sel_valid = $onehot(game_selected);
    sel_idx   = '0;
    for (int g = 0; g < GAMES; g++)
      if (game_selected[g]) sel_idx = GW'(g);
    sel_board = '0;
    load_col  = '0;
    for (int g = 0; g < GAMES; g++) begin
      if (sel_idx == GW'(g))
        sel_board = LAYOUTS[g*COLS*ROWS +: COLS*ROWS];
      for (int c = 0; c < COLS; c++)
        if (game_idx == GW'(g) && load_col_idx == CW'(c))
          load_col = LAYOUTS[(g*COLS+c)*ROWS +: ROWS];
    end
    load_pop = '0;
    for (int r = 0; r < ROWS; r++)
      load_pop = load_pop + SW'(load_col[r]);
    load_sum = ships_reg + load_pop;
    shot_ok  = shot_valid && (shot_col <= COL_LAST) && (shot_row <= ROW_LAST);
    shot_idx = IW'(shot_col) * IW'(ROWS) + IW'(shot_row);
  end

  // Game state machine with registered flags, board, hit map and counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= SELECT;
      board_reg    <= '0;
      hits_reg     <= '0;
      ships_reg    <= '0;
      load_col_idx <= '0;
      game_idx     <= '0;
      busy_reg     <= 1'b0;
      playing_reg  <= 1'b0;
      over_reg     <= 1'b0;
      done_reg     <= 1'b0;
      hit_reg      <= 1'b0;
      dup_reg      <= 1'b0;
    end else if (clear) begin
      // Abort keeps the board so the display still shows the last layout.
      state       <= SELECT;
      hits_reg    <= '0;
      ships_reg   <= '0;
      busy_reg    <= 1'b0;
      playing_reg <= 1'b0;
      over_reg    <= 1'b0;
      done_reg    <= 1'b0;
      hit_reg     <= 1'b0;
      dup_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      hit_reg  <= 1'b0;
      dup_reg  <= 1'b0;
      case (state)
        SELECT: begin
          if (sel_valid) begin
            board_reg <= sel_board;
            if (register_game) begin
              state        <= LOAD;
              busy_reg     <= 1'b1;
              game_idx     <= sel_idx;
              load_col_idx <= '0;
              hits_reg     <= '0;
              ships_reg    <= '0;
            end
          end
        end
        LOAD: begin
          board_reg[int'(load_col_idx)*ROWS +: ROWS] <= load_col;
          ships_reg    <= load_sum;
          load_col_idx <= load_col_idx + CW'(1);
          if (load_col_idx == COL_LAST) begin
            busy_reg <= 1'b0;
            if (load_sum != '0) begin
              state       <= PLAY;
              playing_reg <= 1'b1;
            end else begin
              state    <= OVER;
              over_reg <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (shot_ok) begin
            done_reg <= 1'b1;
            if (hits_reg[shot_idx]) begin
              dup_reg <= 1'b1;
            end else begin
              // Misses also mark the cell so the display can show them.
              hits_reg[shot_idx] <= 1'b1;
              if (board_reg[shot_idx] && ships_reg != '0) begin
                hit_reg   <= 1'b1;
                ships_reg <= ships_reg - SW'(1);
                if (ships_reg == SW'(1)) begin
                  state       <= OVER;
                  playing_reg <= 1'b0;
                  over_reg    <= 1'b1;
                end
              end
            end
          end
        end
        default: ; // OVER holds until clear or reset
      endcase
    end
  end

  assign board_out  = board_reg;
  assign hits_out   = hits_reg;
  assign ships_left = ships_reg;
  assign busy       = busy_reg;
  assign playing    = playing_reg;
  assign game_over  = over_reg;
  assign shot_done  = done_reg;
  assign shot_hit   = hit_reg;
  assign shot_dup   = dup_reg;

endmodule
